// File: rtl/gyrator_sweep_pkg.sv
// Shared types and constants for the gyrator measurement sequencer.
package gyrator_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DC_SETTLE,
        DC_MEAS,
        SP_SETUP,
        SP_SETTLE,
        SP_MEAS,
        RES_OUT,
        DONE
    } state_t;

    localparam logic [1:0] KIND_DC = 2'd0;
    localparam logic [1:0] KIND_P1 = 2'd1;
    localparam logic [1:0] KIND_P2 = 2'd2;

    localparam logic PORT1 = 1'b0;
    localparam logic PORT2 = 1'b1;

endpackage

// File: rtl/gyrator_settle_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational from the count.
module gyrator_settle_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gyrator_sweep_ctrl.sv
// Gyrator bench sequencer: DC operating point, then S-parameter sweep from port 1 and port 2,
// with settle timing, ADC req/ack capture and a valid/ready result stream.
module gyrator_sweep_ctrl
    import gyrator_sweep_pkg::*;
#(
    parameter int FREQ_W   = 16,
    parameter int NPTS_W   = 8,
    parameter int SETTLE_W = 12,
    parameter int DATA_W   = 16,
    parameter int TMO      = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0]   cfg_f_start,
    input  logic [FREQ_W-1:0]   cfg_f_step,
    input  logic [NPTS_W-1:0]   cfg_npts,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic              src_en,
    output logic              src_port,
    output logic [FREQ_W-1:0]   src_freq,
    output logic              dc_mode,
    output logic              adc_req,
    input  logic              adc_ack,
    input  logic [DATA_W-1:0]   adc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic [1:0]          res_kind,
    output logic [NPTS_W-1:0]   res_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);

    state_t state_q, state_d;

    logic [FREQ_W-1:0]   f_start_q, f_step_q, freq_q;
    logic [NPTS_W-1:0]   npts_q, idx_q;
    logic [SETTLE_W-1:0] settle_q, settle_ld_val;
    logic [1:0]          kind_q;
    logic                err_q;
    logic [DATA_W-1:0]   res_data_q;
    logic [1:0]          res_kind_q;
    logic [NPTS_W-1:0]   res_idx_q;

    logic settle_ld, settle_dec, settle_zero;
    logic tmo_ld, tmo_dec, tmo_zero;
    logic accept, capture, advance, timeout;

    logic [NPTS_W:0] idx_inc;
    logic            idx_more, last_pt;

    assign idx_inc  = {1'b0, idx_q} + {{NPTS_W{1'b0}}, 1'b1};
    assign idx_more = (idx_inc < {1'b0, npts_q});
    assign last_pt  = (kind_q == KIND_DC) ? (npts_q == '0)
                                          : ((kind_q == KIND_P2) && !idx_more);

    gyrator_settle_timer #(.W(SETTLE_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_ld),
        .load_val (settle_ld_val),
        .dec      (settle_dec),
        .zero     (settle_zero)
    );

    gyrator_settle_timer #(.W(TMO_W)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmo_ld),
        .load_val (TMO_LOAD),
        .dec      (tmo_dec),
        .zero     (tmo_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        settle_ld     = 1'b0;
        settle_dec    = 1'b0;
        settle_ld_val = settle_q;
        tmo_ld        = 1'b0;
        tmo_dec       = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        advance       = 1'b0;
        timeout       = 1'b0;
        src_en        = 1'b0;
        dc_mode       = 1'b0;
        adc_req       = 1'b0;
        res_valid     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy          = 1'b0;
                done          = (state_q == DONE);
                settle_ld_val = cfg_settle;
                if (start) begin
                    accept    = 1'b1;
                    settle_ld = 1'b1;
                    state_d   = DC_SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            DC_SETTLE, SP_SETTLE: begin
                dc_mode = (state_q == DC_SETTLE);
                src_en  = (state_q == SP_SETTLE);
                if (settle_zero) begin
                    tmo_ld  = 1'b1;
                    state_d = (state_q == DC_SETTLE) ? DC_MEAS : SP_MEAS;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            DC_MEAS, SP_MEAS: begin
                dc_mode = (state_q == DC_MEAS);
                src_en  = (state_q == SP_MEAS);
                adc_req = 1'b1;
                // An ack arriving in the expiry cycle still counts as a capture.
                if (adc_ack) begin
                    capture = 1'b1;
                    state_d = RES_OUT;
                end else if (tmo_zero) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            SP_SETUP: begin
                src_en    = 1'b1;
                settle_ld = 1'b1;
                state_d   = SP_SETTLE;
            end
            RES_OUT: begin
                res_valid = 1'b1;
                dc_mode   = (kind_q == KIND_DC);
                src_en    = (kind_q != KIND_DC);
                if (res_ready) begin
                    advance = 1'b1;
                    state_d = last_pt ? DONE : SP_SETUP;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every transition and suppresses all side effects.
        if (abort) begin
            state_d    = IDLE;
            settle_ld  = 1'b0;
            settle_dec = 1'b0;
            tmo_ld     = 1'b0;
            tmo_dec    = 1'b0;
            accept     = 1'b0;
            capture    = 1'b0;
            advance    = 1'b0;
            timeout    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_start_q  <= '0;
            f_step_q   <= '0;
            npts_q     <= '0;
            settle_q   <= '0;
            kind_q     <= KIND_DC;
            idx_q      <= '0;
            freq_q     <= '0;
            err_q      <= 1'b0;
            res_data_q <= '0;
            res_kind_q <= KIND_DC;
            res_idx_q  <= '0;
        end else begin
            if (accept) begin
                f_start_q <= cfg_f_start;
                f_step_q  <= cfg_f_step;
                npts_q    <= cfg_npts;
                settle_q  <= cfg_settle;
                kind_q    <= KIND_DC;
                idx_q     <= '0;
                err_q     <= 1'b0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (capture) begin
                res_data_q <= adc_data;
                res_kind_q <= kind_q;
                res_idx_q  <= idx_q;
            end
            // Frequency is accumulated; it reloads the start value on each port switch.
            if (advance) begin
                if (kind_q == KIND_DC) begin
                    kind_q <= KIND_P1;
                    idx_q  <= '0;
                    freq_q <= f_start_q;
                end else if (idx_more) begin
                    idx_q  <= idx_inc[NPTS_W-1:0];
                    freq_q <= freq_q + f_step_q;
                end else if (kind_q == KIND_P1) begin
                    kind_q <= KIND_P2;
                    idx_q  <= '0;
                    freq_q <= f_start_q;
                end
            end
        end
    end

    assign src_port = (kind_q == KIND_P2) ? PORT2 : PORT1;
    assign src_freq = freq_q;
    assign res_data = res_data_q;
    assign res_kind = res_kind_q;
    assign res_idx  = res_idx_q;
    assign err      = err_q;

endmodule

// File: tb/tb_gyrator_sweep_ctrl.sv
// Randomized bench for gyrator_sweep_ctrl against a point-list reference model.
module tb_gyrator_sweep_ctrl;

    localparam int FREQ_W   = 16;
    localparam int NPTS_W   = 8;
    localparam int SETTLE_W = 12;
    localparam int DATA_W   = 16;
    localparam int TMO      = 1023;

    logic clk = 1'b0;
    logic rst_n, start, abort, adc_ack, res_ready;
    logic [FREQ_W-1:0]   cfg_f_start, cfg_f_step;
    logic [NPTS_W-1:0]   cfg_npts;
    logic [SETTLE_W-1:0] cfg_settle;
    logic [DATA_W-1:0]   adc_data;
    logic src_en, src_port, dc_mode, adc_req, res_valid, busy, done, err;
    logic [FREQ_W-1:0]   src_freq;
    logic [DATA_W-1:0]   res_data;
    logic [1:0]          res_kind;
    logic [NPTS_W-1:0]   res_idx;

    gyrator_sweep_ctrl #(
        .FREQ_W(FREQ_W), .NPTS_W(NPTS_W), .SETTLE_W(SETTLE_W), .DATA_W(DATA_W), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step), .cfg_npts(cfg_npts),
        .cfg_settle(cfg_settle), .src_en(src_en), .src_port(src_port), .src_freq(src_freq),
        .dc_mode(dc_mode), .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_kind(res_kind), .res_idx(res_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    int exp_kind[$], exp_idx[$], exp_freq[$], exp_port[$];
    int obs_kind[$], obs_idx[$], obs_data[$], sent_data[$];
    int meas_freq[$], meas_port[$], meas_en[$], meas_dc[$];

    int r_busy, r_done_cyc, r_unstable, r_req_valid, r_req_len, r_delays, r_bp_wait;
    bit r_done, r_bound, r_aborted, r_src_en_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: DC point, then npts points per port with f = f_start + i*f_step mod 2^16.
    task automatic build_model(input int npts, input int fs, input int fst);
        exp_kind.delete(); exp_idx.delete(); exp_freq.delete(); exp_port.delete();
        obs_kind.delete(); obs_idx.delete(); obs_data.delete(); sent_data.delete();
        meas_freq.delete(); meas_port.delete(); meas_en.delete(); meas_dc.delete();
        exp_kind.push_back(0); exp_idx.push_back(0); exp_freq.push_back(0); exp_port.push_back(0);
        for (int p = 1; p <= 2; p++) begin
            for (int i = 0; i < npts; i++) begin
                exp_kind.push_back(p);
                exp_idx.push_back(i);
                exp_freq.push_back((fs + i * fst) % 65536);
                exp_port.push_back(p - 1);
            end
        end
    endtask

    function automatic int exp_busy(input int npts, input int settle);
        return (settle + 3) + 2 * npts * (settle + 4);
    endfunction

    task automatic do_start(input int npts, input int settle, input int fs, input int fst);
        cfg_npts    = NPTS_W'(npts);
        cfg_settle  = SETTLE_W'(settle);
        cfg_f_start = FREQ_W'(fs);
        cfg_f_step  = FREQ_W'(fst);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Acts as ADC and result consumer until done, return to idle, abort, or the cycle bound.
    task automatic run(input int max_cyc, input int ack_lo, input int ack_hi, input int rdy_max,
                       input int bp_kind, input int bp_idx, input int bp_len,
                       input int abort_n, input bit noise);
        int req_wait, val_wait, req_dly, rdy_dly, p2_cnt;
        logic [DATA_W+2+NPTS_W-1:0] snap;
        req_wait = 0; val_wait = 0; req_dly = 0; rdy_dly = 0; p2_cnt = 0; snap = '0;
        r_busy = 0; r_done_cyc = 0; r_unstable = 0; r_req_valid = 0; r_req_len = 0;
        r_delays = 0; r_bp_wait = 0;
        r_done = 0; r_bound = 0; r_aborted = 0; r_src_en_seen = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            adc_ack = 1'b0; res_ready = 1'b0; start = 1'b0;
            if (busy) r_busy++;
            if (src_en) r_src_en_seen = 1;
            if (done) begin r_done = 1; r_done_cyc = c; return; end
            if (!busy) return;
            if (abort_n > 0 && src_en && src_port && !adc_req && !res_valid) begin
                p2_cnt++;
                if (p2_cnt == abort_n) begin
                    abort = 1'b1; tick(); abort = 1'b0; r_aborted = 1; return;
                end
            end
            if (adc_req) begin
                if (req_wait == 0) begin
                    req_dly = (ack_hi < 0) ? -1 : ack_lo + int'($urandom_range(ack_hi - ack_lo));
                    if (req_dly > 0) r_delays += req_dly;
                    meas_freq.push_back(int'(src_freq)); meas_port.push_back(int'(src_port));
                    meas_en.push_back(int'(src_en)); meas_dc.push_back(int'(dc_mode));
                end
                if (req_wait == req_dly) begin
                    adc_ack = 1'b1;
                    adc_data = DATA_W'($urandom);
                    sent_data.push_back(int'(adc_data));
                end
                req_wait++;
                if (req_wait > r_req_len) r_req_len = req_wait;
            end else begin
                req_wait = 0;
            end
            if (res_valid) begin
                if (adc_req) r_req_valid++;
                if (val_wait == 0) begin
                    snap = {res_data, res_kind, res_idx};
                    rdy_dly = (int'(res_kind) == bp_kind && int'(res_idx) == bp_idx) ?
                              bp_len : int'($urandom_range(rdy_max));
                    r_delays += rdy_dly;
                end else if ({res_data, res_kind, res_idx} !== snap) begin
                    r_unstable++;
                end
                if (val_wait == rdy_dly) begin
                    res_ready = 1'b1;
                    obs_kind.push_back(int'(res_kind)); obs_idx.push_back(int'(res_idx));
                    obs_data.push_back(int'(res_data));
                    if (int'(res_kind) == bp_kind && int'(res_idx) == bp_idx) r_bp_wait = val_wait + 1;
                end
                val_wait++;
            end else begin
                val_wait = 0;
            end
            if (noise) begin
                start = 1'($urandom_range(1));
                cfg_npts = NPTS_W'($urandom); cfg_settle = SETTLE_W'($urandom);
                cfg_f_start = FREQ_W'($urandom); cfg_f_step = FREQ_W'($urandom);
            end
            tick();
        end
        r_bound = 1;
        adc_ack = 1'b0; res_ready = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; adc_ack = 1'b0; res_ready = 1'b0;
        adc_data = '0; cfg_f_start = '0; cfg_f_step = '0; cfg_npts = '0; cfg_settle = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({src_en, src_port, src_freq, dc_mode, adc_req, res_valid, res_data, res_kind,
             res_idx, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got src_en=%b busy=%b err=%b res_valid=%b required all 0",
                     src_en, busy, err, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({busy, done, adc_req, src_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b required 0", busy, done);
        end
    endtask

    task automatic test_nominal();
        build_model(2, 100, 50);
        do_start(2, 2, 100, 50);
        run(200, 0, 0, 0, -1, 0, 0, 0, 0);
        n_cmp++;
        if (!r_done || r_done_cyc != 30) begin
            n_fail++; $display("FAIL nominal_done_cycle: got %0d required 30", r_done_cyc);
        end
        n_cmp++;
        if (r_busy != 29) begin n_fail++; $display("FAIL nominal_busy: got %0d required 29", r_busy); end
        n_cmp++;
        if (obs_kind.size() != 5 || meas_freq.size() != 5) begin
            n_fail++; $display("FAIL nominal_count: got %0d required 5", obs_kind.size());
        end
        for (int i = 0; i < 5 && i < obs_kind.size() && i < meas_freq.size(); i++) begin
            n_cmp++;
            if (obs_kind[i] != exp_kind[i] || obs_idx[i] != exp_idx[i] || obs_data[i] != sent_data[i]) begin
                n_fail++;
                $display("FAIL nominal_result[%0d]: got kind=%0d idx=%0d data=%0h required kind=%0d idx=%0d data=%0h",
                         i, obs_kind[i], obs_idx[i], obs_data[i], exp_kind[i], exp_idx[i], sent_data[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (meas_freq[i] != exp_freq[i] || meas_port[i] != exp_port[i] || meas_en[i] != 1 || meas_dc[i] != 0) begin
                    n_fail++;
                    $display("FAIL nominal_source[%0d]: got freq=%0d port=%0d en=%0d required freq=%0d port=%0d en=1",
                             i, meas_freq[i], meas_port[i], meas_en[i], exp_freq[i], exp_port[i]);
                end
            end
        end
    endtask

    task automatic test_npts0();
        build_model(0, 7, 9);
        do_start(0, 1, 7, 9);
        run(100, 0, 2, 2, -1, 0, 0, 0, 0);
        n_cmp++;
        if (!r_done || obs_kind.size() != 1) begin
            n_fail++; $display("FAIL npts0_results: got %0d results done=%0d required 1 and done", obs_kind.size(), r_done);
        end else if (obs_kind[0] != 0 || obs_idx[0] != 0 || obs_data[0] != sent_data[0] || meas_dc[0] != 1) begin
            n_fail++; $display("FAIL npts0_dc: got kind=%0d idx=%0d required kind=0 idx=0", obs_kind[0], obs_idx[0]);
        end
        n_cmp++;
        if (r_src_en_seen) begin n_fail++; $display("FAIL npts0_src_en: got 1 required 0"); end
    endtask

    task automatic test_backpressure();
        build_model(2, 300, 11);
        do_start(2, 1, 300, 11);
        run(300, 0, 0, 0, 1, 0, 7, 0, 0);
        n_cmp++;
        if (r_bp_wait != 8 || r_unstable != 0 || r_req_valid != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got valid_cycles=%0d unstable=%0d req_during_valid=%0d required 8/0/0",
                     r_bp_wait, r_unstable, r_req_valid);
        end
        n_cmp++;
        if (!r_done || r_busy != exp_busy(2, 1) + 7) begin
            n_fail++; $display("FAIL bp_busy: got %0d required %0d", r_busy, exp_busy(2, 1) + 7);
        end
        n_cmp++;
        if (obs_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d required %0d", obs_kind.size(), exp_kind.size());
        end else begin
            for (int i = 0; i < obs_kind.size(); i++) begin
                n_cmp++;
                if (obs_kind[i] != exp_kind[i] || obs_idx[i] != exp_idx[i] || obs_data[i] != sent_data[i]) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d]: got kind=%0d idx=%0d required kind=%0d idx=%0d",
                             i, obs_kind[i], obs_idx[i], exp_kind[i], exp_idx[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        build_model(2, 'hFFF0, 'h20);
        do_start(2, 0, 'hFFF0, 'h20);
        run(200, 0, 0, 0, -1, 0, 0, 0, 0);
        n_cmp++;
        if (!r_done || r_busy != exp_busy(2, 0)) begin
            n_fail++; $display("FAIL wrap_busy: got %0d required %0d", r_busy, exp_busy(2, 0));
        end
        n_cmp++;
        if (meas_freq.size() != 5) begin
            n_fail++; $display("FAIL wrap_count: got %0d required 5", meas_freq.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                n_cmp++;
                if (meas_freq[i] != exp_freq[i] || meas_port[i] != exp_port[i]) begin
                    n_fail++;
                    $display("FAIL wrap_freq[%0d]: got %0h port=%0d required %0h port=%0d",
                             i, meas_freq[i], meas_port[i], exp_freq[i], exp_port[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        build_model(0, 0, 0);
        do_start(0, 1, 0, 0);
        run(3000, 0, -1, 0, -1, 0, 0, 0, 0);
        n_cmp++;
        if (r_done || r_bound || r_req_len != TMO || r_busy != 2 + TMO) begin
            n_fail++;
            $display("FAIL tmo_expiry: got req_cycles=%0d busy=%0d done=%0d required %0d/%0d/0",
                     r_req_len, r_busy, r_done, TMO, 2 + TMO);
        end
        n_cmp++;
        if (err !== 1'b1 || src_en !== 1'b0 || adc_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_state: got err=%b src_en=%b adc_req=%b busy=%b required 1/0/0/0",
                               err, src_en, adc_req, busy);
        end
        tick(); tick();
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL tmo_sticky: got err=%b done=%b required 1/0", err, done);
        end
        build_model(0, 0, 0);
        do_start(0, 0, 0, 0);
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got err=%b required 0", err); end
        // Ack in the last allowed request cycle is a successful capture.
        run(3000, TMO - 1, TMO - 1, 0, -1, 0, 0, 0, 0);
        n_cmp++;
        if (!r_done || err !== 1'b0 || r_req_len != TMO || obs_kind.size() != 1) begin
            n_fail++; $display("FAIL tmo_last_ack: got done=%0d err=%b req_cycles=%0d required 1/0/%0d",
                               r_done, err, r_req_len, TMO);
        end
    endtask

    task automatic test_abort();
        int dn;
        build_model(2, 40, 4);
        do_start(2, 3, 40, 4);
        run(300, 0, 1, 1, -1, 0, 0, 2, 0);
        n_cmp++;
        if (!r_aborted || busy !== 1'b0 || src_en !== 1'b0 || adc_req !== 1'b0 ||
            res_valid !== 1'b0 || dc_mode !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: got aborted=%0d busy=%b src_en=%b required 1/0/0",
                               r_aborted, busy, src_en);
        end
        n_cmp++;
        if (obs_kind.size() != 3) begin
            n_fail++; $display("FAIL abort_partial: got %0d results required 3", obs_kind.size());
        end
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            tick();
        end
        n_cmp++;
        if (dn != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", dn); end
        build_model(1, 5, 6);
        do_start(1, 1, 5, 6);
        run(300, 0, 0, 0, -1, 0, 0, 0, 0);
        n_cmp++;
        if (!r_done || obs_kind.size() != 3 || r_busy != exp_busy(1, 1)) begin
            n_fail++; $display("FAIL abort_restart: got results=%0d busy=%0d required 3/%0d",
                               obs_kind.size(), r_busy, exp_busy(1, 1));
        end
    endtask

    task automatic test_random();
        int npts, settle, fs, fst;
        for (int it = 0; it < 8; it++) begin
            npts = int'($urandom_range(4)); settle = int'($urandom_range(5));
            fs = int'($urandom_range(65535)); fst = int'($urandom_range(65535));
            build_model(npts, fs, fst);
            do_start(npts, settle, fs, fst);
            run(2000, 0, 3, 3, -1, 0, 0, 0, 1);
            n_cmp++;
            if (!r_done || r_busy != exp_busy(npts, settle) + r_delays) begin
                n_fail++; $display("FAIL rand%0d_busy: got %0d done=%0d required %0d",
                                   it, r_busy, r_done, exp_busy(npts, settle) + r_delays);
            end
            n_cmp++;
            if (obs_kind.size() != exp_kind.size() || meas_freq.size() != exp_kind.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", it, obs_kind.size(), exp_kind.size());
            end else begin
                for (int i = 0; i < exp_kind.size(); i++) begin
                    n_cmp++;
                    if (obs_kind[i] != exp_kind[i] || obs_idx[i] != exp_idx[i] || obs_data[i] != sent_data[i] ||
                        meas_dc[i] != (exp_kind[i] == 0 ? 1 : 0) || meas_en[i] != (exp_kind[i] == 0 ? 0 : 1) ||
                        (exp_kind[i] != 0 && (meas_freq[i] != exp_freq[i] || meas_port[i] != exp_port[i]))) begin
                        n_fail++;
                        $display("FAIL rand%0d_pt[%0d]: got kind=%0d idx=%0d freq=%0h port=%0d required kind=%0d idx=%0d freq=%0h port=%0d",
                                 it, i, obs_kind[i], obs_idx[i], meas_freq[i], meas_port[i],
                                 exp_kind[i], exp_idx[i], exp_freq[i], exp_port[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_start(2, 3, 1000, 10);
        n = 0;
        while (!src_en && n < 100) begin
            adc_ack = adc_req; adc_data = 16'h5A5A; res_ready = res_valid;
            tick();
            n++;
        end
        adc_ack = 1'b0; res_ready = 1'b0;
        n_cmp++;
        if (src_en !== 1'b1) begin n_fail++; $display("FAIL areset_reach: got src_en=%b required 1", src_en); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({src_en, src_port, src_freq, dc_mode, adc_req, res_valid, res_data, res_kind,
             res_idx, busy, done, err} !== '0) begin
            n_fail++; $display("FAIL areset_outputs: got src_en=%b busy=%b src_freq=%0h res_data=%0h required 0",
                               src_en, busy, src_freq, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_npts0();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_abort();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
